mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port RAM between two requesters: the CPU core and the PPB debug probe path. The probe path gives the host backdoor read/write access to memory.
- Sits between the requesters and the RAM's CS/WE/address/write-data/read-data pins.
- Fixed CPU priority, with an anti-starvation counter that forces a debug grant.
- Non-pipelined: one access in flight at a time.

Parameters:
- ADDR_W, 8, address bus width
- DATA_W, 8, data bus width
- RD_LATENCY, 1, cycles from RAM CS (read) to valid mem_rdata; legal range 1..4
- STARVE_LIMIT, 4, consecutive CPU grants allowed while dbg_req is pending before debug is forced; 0 = strict CPU priority

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  read data returned to CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same directions, widths and meanings as the cpu_* ports, for the debug probe
- mem_cs  out  1  RAM chip select
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous): state = IDLE; every output = 0; starvation counter = 0; any in-flight read is dropped and no rvalid is produced after reset is released.
- States:
  - IDLE: samples requests.
  - ACCESS: exactly 1 cycle.
  - RDWAIT: RD_LATENCY cycles.
  - RETURN: 1 cycle.
- IDLE, no request: stay in IDLE.
- IDLE, any request present: pick a winner, latch its we/addr/wdata into the mem_* registers, go to ACCESS.
- Winner selection:
  - Debug wins if dbg_req=1 and (cpu_req=0 or starve count >= STARVE_LIMIT, with STARVE_LIMIT != 0).
  - Otherwise the CPU wins.
- ACCESS: mem_cs=1, mem_we = latched we, winner's gnt=1.
  - Write: next state IDLE.
  - Read: next state RDWAIT.
- RDWAIT: count RD_LATENCY cycles, capture mem_rdata on the last one, then go to RETURN.
- RETURN: the owner's rvalid=1 with its rdata = captured value. The other requester's rdata holds its previous value. Next state IDLE.
- Latency from request first seen in IDLE (cycle N):
  - gnt at N+1.
  - Write committed at N+1.
  - Read with RD_LATENCY=1: rvalid at N+3.
  - Next access can issue no earlier than N+3 after a write, or N+5 after a read.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - Drop req the cycle after gnt unless a new access is wanted.
  - The arbiter samples only in IDLE, so a req still high in IDLE is treated as a new request.
- Starvation counter, updated at each IDLE arbitration:
  - Increments (saturating at STARVE_LIMIT) when the CPU wins while dbg_req=1.
  - Clears when debug wins or when dbg_req=0.
- Simultaneous requests with the counter below the limit: CPU wins.
- mem_we and mem_addr hold their last values when mem_cs=0.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs cpu_gnt_cnt[15:0], dbg_gnt_cnt[15:0] and dbg_wait_cnt[15:0].
  - cpu_gnt_cnt and dbg_gnt_cnt: per-requester grant counts.
  - dbg_wait_cnt: cycles with dbg_req=1 and no dbg_gnt.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; the core behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> all outputs 0, busy=0.
- CPU write then read: write addr 8'h10, data 8'hA5 -> cpu_gnt 1 cycle after req, mem_cs=1, mem_we=1; read 8'h10 (RAM model, latency 1) -> cpu_rvalid at N+3, cpu_rdata=8'hA5, dbg_rvalid stays 0.
- Contention: cpu_req and dbg_req both held high, back-to-back reads, STARVE_LIMIT=4 -> grant sequence CPU,CPU,CPU,CPU,DBG,CPU,...
- STARVE_LIMIT=0 with both requesters always requesting -> dbg_gnt never asserts over 50 accesses.
- Reset mid-read: assert rst during RDWAIT -> no rvalid after release; first new request is granted normally.
- With MEM_ARB_PERF_EN defined: 3 CPU and 2 DBG grants -> cpu_gnt_cnt=3, dbg_gnt_cnt=2, dbg_wait_cnt = counted stall cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side bus bundle for mem_arbiter
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_cs;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_cs, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_cs, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug single-port RAM arbiter with anti-starvation
// Optional grant/wait counters under MEM_ARB_PERF_EN.
module mem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]  cpu_gnt_cnt,
   output logic [15:0]  dbg_gnt_cnt,
   output logic [15:0]  dbg_wait_cnt
`endif
);

   localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_LIMIT);
   localparam logic [1:0]      LAT_LAST = 2'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RDWAIT,
      S_RETURN
   } state_t;

   state_t            state_q, state_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic [1:0]        lat_q, lat_d;
   logic              owner_q, owner_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              dbg_rvalid_q, dbg_rvalid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              busy_q, busy_d;
   logic              dbg_wins;

`ifdef MEM_ARB_PERF_EN
   logic [15:0] cpu_gnt_cnt_q, cpu_gnt_cnt_d;
   logic [15:0] dbg_gnt_cnt_q, dbg_gnt_cnt_d;
   logic [15:0] dbg_wait_cnt_q, dbg_wait_cnt_d;
`endif

   // The counter saturates, so equality with the limit means "starved".
   assign dbg_wins = bus.dbg_req &&
                     (!bus.cpu_req || ((STARVE_LIMIT != 0) && (starve_q == SC_MAX)));

   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      lat_d        = lat_q;
      owner_d      = owner_q;
      mem_cs_d     = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_gnt_d    = 1'b0;
      dbg_gnt_d    = 1'b0;
      cpu_rvalid_d = 1'b0;
      dbg_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.dbg_req && !dbg_wins)
               starve_d = (starve_q == SC_MAX) ? starve_q : starve_q + SC_W'(1);
            else
               starve_d = '0;
            if (bus.cpu_req || bus.dbg_req) begin
               owner_d     = dbg_wins;
               mem_cs_d    = 1'b1;
               mem_we_d    = dbg_wins ? bus.dbg_we    : bus.cpu_we;
               mem_addr_d  = dbg_wins ? bus.dbg_addr  : bus.cpu_addr;
               mem_wdata_d = dbg_wins ? bus.dbg_wdata : bus.cpu_wdata;
               cpu_gnt_d   = !dbg_wins;
               dbg_gnt_d   = dbg_wins;
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            lat_d   = 2'd0;
            state_d = mem_we_q ? S_IDLE : S_RDWAIT;
         end
         S_RDWAIT: begin
            if (lat_q == LAT_LAST) begin
               if (owner_q) begin
                  dbg_rdata_d  = bus.mem_rdata;
                  dbg_rvalid_d = 1'b1;
               end else begin
                  cpu_rdata_d  = bus.mem_rdata;
                  cpu_rvalid_d = 1'b1;
               end
               state_d = S_RETURN;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         S_RETURN: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

`ifdef MEM_ARB_PERF_EN
   always_comb begin
      cpu_gnt_cnt_d  = cpu_gnt_cnt_q;
      dbg_gnt_cnt_d  = dbg_gnt_cnt_q;
      dbg_wait_cnt_d = dbg_wait_cnt_q;
      if (cpu_gnt_d && (cpu_gnt_cnt_q != 16'hFFFF))
         cpu_gnt_cnt_d = cpu_gnt_cnt_q + 16'd1;
      if (dbg_gnt_d && (dbg_gnt_cnt_q != 16'hFFFF))
         dbg_gnt_cnt_d = dbg_gnt_cnt_q + 16'd1;
      if (bus.dbg_req && !dbg_gnt_q && (dbg_wait_cnt_q != 16'hFFFF))
         dbg_wait_cnt_d = dbg_wait_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_gnt_cnt_q  <= 16'd0;
         dbg_gnt_cnt_q  <= 16'd0;
         dbg_wait_cnt_q <= 16'd0;
      end else begin
         cpu_gnt_cnt_q  <= cpu_gnt_cnt_d;
         dbg_gnt_cnt_q  <= dbg_gnt_cnt_d;
         dbg_wait_cnt_q <= dbg_wait_cnt_d;
      end
   end

   assign cpu_gnt_cnt  = cpu_gnt_cnt_q;
   assign dbg_gnt_cnt  = dbg_gnt_cnt_q;
   assign dbg_wait_cnt = dbg_wait_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         starve_q     <= '0;
         lat_q        <= 2'd0;
         owner_q      <= 1'b0;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         lat_q        <= lat_d;
         owner_q      <= owner_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dbg_gnt    = dbg_gnt_q;
   assign bus.dbg_rvalid = dbg_rvalid_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
   assign bus.mem_cs     = mem_cs_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.busy       = busy_q;

endmodule
